// File: rtl/tiro_inimigo_pkg.sv
// Shared game constants for the enemy-shot block: sprite sizes, screen limits,
// FSM encoding and helpers to slice the packed per-enemy coordinate buses.
package tiro_inimigo_pkg;

  localparam int N_INIMIGOS = 5;
  localparam int COORD_W    = 10;

  localparam int INIM_W = 33;
  localparam int INIM_H = 24;
  localparam int NAVE_Y = 440;
  localparam int NAVE_W = 33;
  localparam int NAVE_H = 20;
  localparam int TIRO_W = 4;
  localparam int TIRO_H = 10;

  localparam int Y_LIMITE = 480;
  // Horizontal offset from the enemy's left edge to the shot's left edge.
  localparam int X_CANO   = 14;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    SELECIONA = 2'd1,
    VOO       = 2'd2
  } estado_t;

  function automatic logic [COORD_W-1:0] fatia(
    input logic [N_INIMIGOS*COORD_W-1:0] bus,
    input logic [2:0]                    i
  );
    return bus[COORD_W*i +: COORD_W];
  endfunction

  // Map a 3-bit random value onto 0..N_INIMIGOS-1.
  function automatic logic [2:0] dobra_idx(input logic [2:0] v);
    return (v >= 3'(N_INIMIGOS)) ? v - 3'(N_INIMIGOS) : v;
  endfunction

endpackage

// File: rtl/tiro_inimigo_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), reloads SEED on reset, steps when enabled.
// Only the low three bits are exported; they pick the first candidate shooter.
module tiro_inimigo_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       CLOCK_MV,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [2:0] low3_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge CLOCK_MV) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign low3_o = lfsr_q[2:0];

endmodule

// File: rtl/tiro_inimigo.sv
// Enemy-shot generator: periodically launches one shot from a pseudo-random live
// enemy, moves it down each tick and pulses acerto_nave when it hits the ship.
module tiro_inimigo
  import tiro_inimigo_pkg::*;
#(
  parameter int INTERVALO = 64,
  parameter int VEL_Y     = 4
) (
  input  logic                            CLOCK_MV,
  input  logic                            reset,
  input  logic                            pausa,
  input  logic                            reiniciarJogo,
  input  logic [N_INIMIGOS*COORD_W-1:0]   inimigo_x,
  input  logic [N_INIMIGOS*COORD_W-1:0]   inimigo_y,
  input  logic [N_INIMIGOS-1:0]           vivo,
  input  logic [COORD_W-1:0]              nave_x,
  output logic [COORD_W-1:0]              tiro_x,
  output logic [COORD_W-1:0]              tiro_y,
  output logic                            tiro_ativo,
  output logic                            acerto_nave
);

  localparam int CW = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
  localparam logic [CW-1:0] CONT_INI = CW'(INTERVALO - 1);

  estado_t              estado_q;
  logic [CW-1:0]        cont_q;
  logic [2:0]           idx_q;
  logic [2:0]           tent_q;
  logic [COORD_W-1:0]   tiro_x_q;
  logic [COORD_W-1:0]   tiro_y_q;
  logic                 ativo_q;
  logic                 acerto_q;

  logic                 rst_w;
  logic [2:0]           sorteio_w;
  logic [10:0]          tx_w, ty_w, nx_w;
  logic                 acerto_w;
  logic                 fundo_w;

  assign rst_w = reset || reiniciarJogo;

  tiro_inimigo_lfsr8 #(.SEED(8'hA5)) u_lfsr (
    .CLOCK_MV (CLOCK_MV),
    .rst_i    (rst_w),
    .en_i     (!pausa),
    .low3_o   (sorteio_w)
  );

  // Collision and bottom-exit are evaluated in 11 bits so edge sums never wrap.
  assign tx_w = {1'b0, tiro_x_q};
  assign ty_w = {1'b0, tiro_y_q};
  assign nx_w = {1'b0, nave_x};

  assign acerto_w = (ty_w + 11'(TIRO_H) >= 11'(NAVE_Y))
                 && (ty_w < 11'(NAVE_Y + NAVE_H))
                 && (tx_w + 11'(TIRO_W) > nx_w)
                 && (tx_w < nx_w + 11'(NAVE_W));

  assign fundo_w = (ty_w + 11'(VEL_Y) >= 11'(Y_LIMITE));

  always_ff @(posedge CLOCK_MV) begin
    if (rst_w) begin
      estado_q <= ESPERA;
      cont_q   <= CONT_INI;
      idx_q    <= '0;
      tent_q   <= '0;
      tiro_x_q <= '0;
      tiro_y_q <= '0;
      ativo_q  <= 1'b0;
      acerto_q <= 1'b0;
    end else if (pausa) begin
      acerto_q <= 1'b0;
    end else begin
      acerto_q <= 1'b0;
      unique case (estado_q)
        ESPERA: begin
          if (cont_q == '0) begin
            estado_q <= SELECIONA;
            idx_q    <= dobra_idx(sorteio_w);
            tent_q   <= '0;
          end else begin
            cont_q <= cont_q - 1'b1;
          end
        end
        SELECIONA: begin
          if (vivo[idx_q]) begin
            tiro_x_q <= fatia(inimigo_x, idx_q) + 10'(X_CANO);
            tiro_y_q <= fatia(inimigo_y, idx_q) + 10'(INIM_H);
            ativo_q  <= 1'b1;
            estado_q <= VOO;
          end else begin
            idx_q <= (idx_q == 3'(N_INIMIGOS - 1)) ? 3'd0 : idx_q + 3'd1;
            // Every candidate dead: give up this round and wait a full interval.
            if (tent_q == 3'(N_INIMIGOS - 1)) begin
              estado_q <= ESPERA;
              cont_q   <= CONT_INI;
            end else begin
              tent_q <= tent_q + 3'd1;
            end
          end
        end
        VOO: begin
          if (acerto_w) begin
            acerto_q <= 1'b1;
            ativo_q  <= 1'b0;
            estado_q <= ESPERA;
            cont_q   <= CONT_INI;
          end else if (fundo_w) begin
            ativo_q  <= 1'b0;
            estado_q <= ESPERA;
            cont_q   <= CONT_INI;
          end else begin
            tiro_y_q <= tiro_y_q + 10'(VEL_Y);
          end
        end
        default: estado_q <= ESPERA;
      endcase
    end
  end

  assign tiro_x      = tiro_x_q;
  assign tiro_y      = tiro_y_q;
  assign tiro_ativo  = ativo_q;
  assign acerto_nave = acerto_q;

endmodule

// File: tb/tb_tiro_inimigo.sv
// Bench for tiro_inimigo: directed scenarios plus randomized play, every cycle
// compared against a behavioural model of the shot rules.
module tb_tiro_inimigo;

  localparam int INTERVALO = 64;

  logic        CLOCK_MV = 1'b0;
  logic        reset = 1'b1;
  logic        pausa = 1'b0;
  logic        reiniciarJogo = 1'b0;
  logic [49:0] inimigo_x;
  logic [49:0] inimigo_y;
  logic [4:0]  vivo = 5'b11111;
  logic [9:0]  nave_x = '0;
  logic [9:0]  tiro_x;
  logic [9:0]  tiro_y;
  logic        tiro_ativo;
  logic        acerto_nave;

  tiro_inimigo dut (
    .CLOCK_MV      (CLOCK_MV),
    .reset         (reset),
    .pausa         (pausa),
    .reiniciarJogo (reiniciarJogo),
    .inimigo_x     (inimigo_x),
    .inimigo_y     (inimigo_y),
    .vivo          (vivo),
    .nave_x        (nave_x),
    .tiro_x        (tiro_x),
    .tiro_y        (tiro_y),
    .tiro_ativo    (tiro_ativo),
    .acerto_nave   (acerto_nave)
  );

  always #5 CLOCK_MV = ~CLOCK_MV;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference LFSR sequence from the polynomial, indexed by steps since reset.
  logic [7:0] seq [256];

  // Behavioural model: waiting countdown, candidate scan, shot in flight.
  bit   chk_en = 1'b0;
  int   m_mode;       // 0 waiting, 1 choosing shooter, 2 shot flying
  int   m_wait;
  int   m_start;
  int   m_j;
  int   m_steps;
  int   ex, ey;
  bit   eact, ehit;
  int   c_tmp;
  int   nx_tmp;
  logic [7:0] cur;

  function automatic int ix(input int i);
    return int'(inimigo_x[10*i +: 10]);
  endfunction

  function automatic int iy(input int i);
    return int'(inimigo_y[10*i +: 10]);
  endfunction

  always @(posedge CLOCK_MV) begin
    if (reset || reiniciarJogo) begin
      m_mode = 0; m_wait = INTERVALO; m_steps = 0;
      ex = 0; ey = 0; eact = 0; ehit = 0;
      chk_en = 1'b1;
    end else if (chk_en && pausa) begin
      ehit = 0;
    end else if (chk_en) begin
      cur = seq[m_steps % 255];
      m_steps++;
      ehit = 0;
      case (m_mode)
        0: begin
          m_wait--;
          if (m_wait == 0) begin
            m_mode  = 1;
            m_start = int'(cur[2:0]);
            if (m_start >= 5) m_start -= 5;
            m_j = 0;
          end
        end
        1: begin
          c_tmp = (m_start + m_j) % 5;
          if (vivo[c_tmp]) begin
            ex = ix(c_tmp) + 14;
            ey = iy(c_tmp) + 24;
            eact = 1; m_mode = 2;
          end else begin
            m_j++;
            if (m_j == 5) begin m_mode = 0; m_wait = INTERVALO; end
          end
        end
        default: begin
          nx_tmp = int'(nave_x);
          if (ey + 10 >= 440 && ey < 460 && ex + 4 > nx_tmp && ex < nx_tmp + 33) begin
            ehit = 1; eact = 0; m_mode = 0; m_wait = INTERVALO;
          end else if (ey + 4 >= 480) begin
            eact = 0; m_mode = 0; m_wait = INTERVALO;
          end else begin
            ey += 4;
          end
        end
      endcase
    end
  end

  always @(negedge CLOCK_MV) begin
    if (chk_en) begin
      chk("cyc_tiro_x", int'(tiro_x), ex);
      chk("cyc_tiro_y", int'(tiro_y), ey);
      chk("cyc_tiro_ativo", int'(tiro_ativo), int'(eact));
      chk("cyc_acerto_nave", int'(acerto_nave), int'(ehit));
    end
  end

  task automatic wait_launch(input string nm);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge CLOCK_MV);
      if (tiro_ativo) break;
    end
    if (n >= 200) chk(nm, 0, 1);
  endtask

  initial begin
    int n;
    int seen;
    int sv;
    for (int i = 0; i < 5; i++) begin
      inimigo_x[10*i +: 10] = 10'(50 + 100*i);
      inimigo_y[10*i +: 10] = 10'd90;
    end
    seq[0] = 8'hA5;
    for (int i = 1; i < 256; i++)
      seq[i] = {seq[i-1][6:0], seq[i-1][7] ^ seq[i-1][5] ^ seq[i-1][4] ^ seq[i-1][3]};
    chk("model_lfsr_step1", int'(seq[1]), 8'h4A);
    chk("model_lfsr_period", int'(seq[255]), 8'hA5);

    // Reset state
    @(negedge CLOCK_MV);
    chk("rst_tiro_x", int'(tiro_x), 0);
    chk("rst_tiro_y", int'(tiro_y), 0);
    chk("rst_tiro_ativo", int'(tiro_ativo), 0);
    chk("rst_acerto", int'(acerto_nave), 0);
    @(negedge CLOCK_MV);
    reset = 1'b0;

    // First launch: 64 waiting ticks, then one selection tick
    for (n = 1; n <= 200; n++) begin
      @(negedge CLOCK_MV);
      if (tiro_ativo) break;
    end
    chk("launch_latency", n, 65);
    chk("launch_y", int'(tiro_y), 114);
    chk("launch_x_offset", int'(tiro_x) % 100, 64);

    // Miss: ship far left, shot falls to the bottom
    seen = 0;
    for (n = 0; n < 200; n++) begin
      @(negedge CLOCK_MV);
      if (acerto_nave) seen++;
      if (!tiro_ativo) break;
    end
    chk("miss_timeout", int'(n < 200), 1);
    chk("miss_no_pulse", seen, 0);
    chk("miss_final_y", int'(tiro_y), 478);

    // Hit: park the ship under the next shot
    wait_launch("hit_launch_timeout");
    nave_x = 10'(ex - 14);
    for (n = 0; n < 200; n++) begin
      @(negedge CLOCK_MV);
      if (acerto_nave) break;
    end
    chk("hit_seen", int'(n < 200), 1);
    chk("hit_ativo_low", int'(tiro_ativo), 0);
    chk("hit_y", int'(tiro_y), 430);
    @(negedge CLOCK_MV);
    chk("hit_pulse_width", int'(acerto_nave), 0);

    // Pause mid-flight
    nave_x = '0;
    wait_launch("pause_launch_timeout");
    repeat (5) @(negedge CLOCK_MV);
    sv = ey;
    pausa = 1'b1;
    repeat (10) @(negedge CLOCK_MV);
    chk("pause_hold_y", int'(tiro_y), sv);
    chk("pause_hold_ativo", int'(tiro_ativo), 1);
    pausa = 1'b0;
    @(negedge CLOCK_MV);
    chk("resume_step", int'(tiro_y), sv + 4);

    // Restart mid-flight
    repeat (3) @(negedge CLOCK_MV);
    reiniciarJogo = 1'b1;
    @(negedge CLOCK_MV);
    reiniciarJogo = 1'b0;
    chk("restart_ativo", int'(tiro_ativo), 0);
    chk("restart_y", int'(tiro_y), 0);
    chk("restart_x", int'(tiro_x), 0);

    // All enemies dead, then only enemy 0 alive
    vivo = 5'b00000;
    seen = 0;
    repeat (300) begin
      @(negedge CLOCK_MV);
      if (tiro_ativo) seen++;
    end
    chk("all_dead_no_shot", seen, 0);
    vivo = 5'b00001;
    wait_launch("skip_dead_timeout");
    chk("skip_dead_x", int'(tiro_x), 64);
    chk("skip_dead_y", int'(tiro_y), 114);

    // Randomized play
    for (int k = 0; k < 15000; k++) begin
      @(negedge CLOCK_MV);
      pausa = ($urandom_range(0, 9) == 0);
      reiniciarJogo = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 199) == 0) begin
        for (int i = 0; i < 5; i++) begin
          inimigo_x[10*i +: 10] = 10'($urandom_range(0, 600));
          inimigo_y[10*i +: 10] = 10'($urandom_range(0, 300));
        end
      end
      if ($urandom_range(0, 99) == 0) vivo = 5'($urandom);
      if ($urandom_range(0, 49) == 0) nave_x = 10'($urandom_range(0, 640));
    end

    pausa = 1'b0;
    reiniciarJogo = 1'b0;
    @(negedge CLOCK_MV);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
